// File: rtl/imem_sequencer_pkg.sv
// Shared sizing defaults and controller state type for the instruction-memory sequencer.
package imem_seq_pkg;
  localparam int SEQ_DEPTH = 8;
  localparam int SEQ_AW    = 3;
  localparam int SEQ_IW    = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_FETCH,
    ST_ISSUE,
    ST_HALT
  } seq_state_e;
endpackage

// File: rtl/imem_sequencer_if.sv
// Instruction issue handshake between the sequencer and the datapath.
interface imem_sequencer_if #(
  parameter int IW = 12
) ();
  logic [IW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;

  modport master (output instr, output instr_valid, input instr_ready);
  modport slave  (input instr, input instr_valid, output instr_ready);
endinterface

// File: rtl/instruction_memory.sv
// Instruction store: synchronous write, combinational read on a shared index.
module instruction_memory #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int IW    = 12
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [IW-1:0] wdata,
  output logic [IW-1:0] rdata
);
  logic [IW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/imem_sequencer.sv
// Loads a program into instruction memory, then fetches and issues it one word
// per FETCH+ISSUE pair, with jump redirect and halt on issue acceptance.
import imem_seq_pkg::*;

module imem_sequencer #(
  parameter int DEPTH = SEQ_DEPTH,
  parameter int AW    = SEQ_AW,
  parameter int IW    = SEQ_IW
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prog_start,
  input  logic               prog_valid,
  input  logic [IW-1:0]      prog_data,
  output logic               prog_ready,
  input  logic               run,
  input  logic               halt_req,
  input  logic               jump_valid,
  input  logic [AW-1:0]      jump_target,
  output logic [AW-1:0]      im_index,
  output logic [IW-1:0]      im_data,
  output logic               im_load,
  input  logic [IW-1:0]      im_out,
  imem_sequencer_if.master   issue,
  output logic [AW-1:0]      pc,
  output logic               load_done,
  output logic               halted
);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  seq_state_e    state_reg, state_next;
  logic [AW-1:0] pc_reg, pc_next;
  logic [AW-1:0] wptr_reg, wptr_next;
  logic [IW-1:0] instr_reg, instr_next;
  logic          load_done_reg, load_done_next;
  logic [AW-1:0] pc_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      pc_reg        <= '0;
      wptr_reg      <= '0;
      instr_reg     <= '0;
      load_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pc_reg        <= pc_next;
      wptr_reg      <= wptr_next;
      instr_reg     <= instr_next;
      load_done_reg <= load_done_next;
    end
  end

  // Explicit wrap keeps the PC inside the array even if DEPTH is not a power of two.
  assign pc_inc = (pc_reg == LAST_IDX) ? '0 : pc_reg + 1'b1;

  always_comb begin
    state_next     = state_reg;
    pc_next        = pc_reg;
    wptr_next      = wptr_reg;
    instr_next     = instr_reg;
    load_done_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (prog_start) begin
          state_next = ST_LOAD;
          wptr_next  = '0;
        end else if (run) begin
          state_next = ST_FETCH;
          pc_next    = '0;
        end
      end
      ST_LOAD: begin
        if (prog_valid) begin
          if (wptr_reg == LAST_IDX) begin
            state_next     = ST_IDLE;
            wptr_next      = '0;
            load_done_next = 1'b1;
          end else begin
            wptr_next = wptr_reg + 1'b1;
          end
        end
      end
      ST_FETCH: begin
        instr_next = im_out;
        state_next = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (issue.instr_ready) begin
          pc_next    = jump_valid ? jump_target : pc_inc;
          state_next = halt_req ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        if (prog_start) begin
          state_next = ST_LOAD;
          wptr_next  = '0;
        end else if (run) begin
          state_next = ST_FETCH;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign prog_ready        = (state_reg == ST_LOAD);
  assign im_load           = prog_ready && prog_valid;
  assign im_index          = prog_ready ? wptr_reg : pc_reg;
  assign im_data           = prog_data;
  assign issue.instr       = instr_reg;
  assign issue.instr_valid = (state_reg == ST_ISSUE);
  assign pc                = pc_reg;
  assign load_done         = load_done_reg;
  assign halted            = (state_reg == ST_HALT);
endmodule

// File: tb/tb_imem_sequencer.sv
// Scoreboard bench: sequencer driving the 8x12 instruction memory.
module tb_imem_sequencer;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int IW    = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic          prog_start, prog_valid, run, halt_req, jump_valid;
  logic [IW-1:0] prog_data;
  logic [AW-1:0] jump_target;
  logic          prog_ready, im_load, load_done, halted;
  logic [AW-1:0] im_index, pc;
  logic [IW-1:0] im_data, im_out;

  imem_sequencer_if #(.IW(IW)) issue_if ();

  imem_sequencer #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) dut (
    .clk(clk), .reset(reset),
    .prog_start(prog_start), .prog_valid(prog_valid), .prog_data(prog_data),
    .prog_ready(prog_ready), .run(run), .halt_req(halt_req),
    .jump_valid(jump_valid), .jump_target(jump_target),
    .im_index(im_index), .im_data(im_data), .im_load(im_load), .im_out(im_out),
    .issue(issue_if), .pc(pc), .load_done(load_done), .halted(halted)
  );

  instruction_memory #(.DEPTH(DEPTH), .AW(AW), .IW(IW)) u_mem (
    .clk(clk), .we(im_load), .addr(im_index), .wdata(im_data), .rdata(im_out)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  int load_count = 0;
  int n_accept   = 0;
  int stream_id  = 0;
  int last_acc_stream = -1;
  int last_acc_cycle  = 0;
  bit b2b_mode = 1'b0;
  logic [AW+IW-1:0] exp_load [$];
  logic [IW-1:0]    exp_issue [$];
  logic [IW-1:0]    model_mem [DEPTH];
  int model_pc = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  always @(posedge clk) cycle <= cycle + 1;

  always @(negedge clk) begin
    logic [AW+IW-1:0] el;
    logic [IW-1:0]    ei;
    if (im_load) begin
      load_count++;
      if (exp_load.size() == 0) check_eq("load_unexpected", 1, 0);
      else begin
        el = exp_load.pop_front();
        $display("load  idx=%0d data=0x%03h", im_index, im_data);
        check_eq("load_index", 32'(im_index), 32'(el[AW+IW-1:IW]));
        check_eq("load_data", 32'(im_data), 32'(el[IW-1:0]));
      end
    end
    if (issue_if.instr_valid && issue_if.instr_ready) begin
      n_accept++;
      if (exp_issue.size() == 0) check_eq("issue_unexpected", 1, 0);
      else begin
        ei = exp_issue.pop_front();
        $display("issue instr=0x%03h pc=%0d", issue_if.instr, pc);
        check_eq("issue_instr", 32'(issue_if.instr), 32'(ei));
      end
      if (b2b_mode && last_acc_stream == stream_id)
        check_eq("issue_spacing", cycle - last_acc_cycle, 2);
      last_acc_stream = stream_id;
      last_acc_cycle  = cycle;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_words(input logic [IW-1:0] base, input int n);
    prog_start = 1'b1;
    tick();
    prog_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < (i % 3); g++) begin
        prog_valid = 1'b0;
        tick();
        check_eq("gap_im_load", im_load, 0);
      end
      prog_valid = 1'b1;
      prog_data  = base + IW'(i);
      exp_load.push_back({AW'(i), base + IW'(i)});
      model_mem[i] = base + IW'(i);
      tick();
      prog_valid = 1'b0;
    end
  endtask

  task automatic wait_issue();
    for (int t = 0; t < 10 && !issue_if.instr_valid; t++) tick();
    check_eq("wait_issue", issue_if.instr_valid, 1);
  endtask

  task automatic accept_one(input bit jv, input logic [AW-1:0] jt, input bit hr);
    exp_issue.push_back(model_mem[model_pc]);
    model_pc = jv ? int'(jt) : (model_pc + 1) % DEPTH;
    issue_if.instr_ready = 1'b1;
    jump_valid = jv; jump_target = jt; halt_req = hr;
    tick();
    issue_if.instr_ready = 1'b0;
    jump_valid = 1'b0; halt_req = 1'b0;
    check_eq("accept_pc", 32'(pc), model_pc);
  endtask

  task automatic run_stream(input int n, input bit from_idle);
    int start;
    bit done;
    if (from_idle) model_pc = 0;
    for (int k = 0; k < n; k++) begin
      exp_issue.push_back(model_mem[model_pc]);
      model_pc = (model_pc + 1) % DEPTH;
    end
    start = n_accept;
    stream_id++;
    b2b_mode = 1'b1;
    issue_if.instr_ready = 1'b1;
    run = 1'b1;
    tick();
    run = 1'b0;
    done = 1'b0;
    for (int t = 0; t < 4 * n + 10 && !done; t++) begin
      if (n_accept - start >= n) done = 1'b1;
      else begin
        halt_req = (n_accept - start == n - 1);
        tick();
      end
    end
    halt_req = 1'b0;
    issue_if.instr_ready = 1'b0;
    b2b_mode = 1'b0;
    check_eq("stream_done", done, 1);
    check_eq("stream_halted", halted, 1);
    check_eq("stream_pc", 32'(pc), model_pc);
    if (!done) exp_issue.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pc"}, 32'(pc), 0);
    check_eq({tag, "_instr"}, 32'(issue_if.instr), 0);
    check_eq({tag, "_valid"}, issue_if.instr_valid, 0);
    check_eq({tag, "_prog_ready"}, prog_ready, 0);
    check_eq({tag, "_im_load"}, im_load, 0);
    check_eq({tag, "_load_done"}, load_done, 0);
    check_eq({tag, "_halted"}, halted, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int snap;
    reset = 1'b1;
    prog_start = 1'b0; prog_valid = 1'b0; prog_data = '0; run = 1'b0;
    halt_req = 1'b0; jump_valid = 1'b0; jump_target = '0;
    issue_if.instr_ready = 1'b0;
    #2 reset = 1'b0;
    #1 check_reset_outputs("por");
    tick();
    reset = 1'b1;
    tick();

    // Full program load with valid gaps
    snap = load_count;
    load_words(12'h101, 8);
    check_eq("load_pulses", load_count - snap, 8);
    check_eq("load_done_pulse", load_done, 1);
    check_eq("load_exit_ready", prog_ready, 0);
    tick();
    check_eq("load_done_clear", load_done, 0);

    // Back-to-back run with PC wrap 7->0
    run_stream(9, 1'b1);

    // Stall, jump and halt/resume
    stream_id++;
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_issue();
    jump_valid = 1'b1; jump_target = 3'd3; halt_req = 1'b1;
    for (int s = 0; s < 5; s++) begin
      tick();
      check_eq("stall_valid", issue_if.instr_valid, 1);
      check_eq("stall_instr", 32'(issue_if.instr), 32'(model_mem[model_pc]));
      check_eq("stall_pc", 32'(pc), model_pc);
    end
    jump_valid = 1'b0; halt_req = 1'b0;
    accept_one(1'b0, 3'd0, 1'b0);
    wait_issue();
    check_eq("pre_jump_pc", 32'(pc), 2);
    accept_one(1'b1, 3'd6, 1'b0);
    wait_issue();
    check_eq("jump_instr", 32'(issue_if.instr), 32'h107);
    accept_one(1'b0, 3'd0, 1'b1);
    check_eq("halt_halted", halted, 1);
    check_eq("halt_valid", issue_if.instr_valid, 0);
    run = 1'b1;
    tick();
    run = 1'b0;
    wait_issue();
    check_eq("resume_instr", 32'(issue_if.instr), 32'h108);
    accept_one(1'b0, 3'd0, 1'b1);
    check_eq("resume_halted", halted, 1);

    // Reset after 4 of 8 transfers
    snap = load_count;
    load_words(12'h201, 4);
    check_eq("partial_pulses", load_count - snap, 4);
    prog_valid = 1'b1;
    prog_data  = 12'h2AA;
    #2 reset = 1'b0;
    #1 check_reset_outputs("midload");
    prog_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run_stream(8, 1'b1);

    // Full reload, then run from entry 0
    load_words(12'h301, 8);
    tick();
    run_stream(3, 1'b1);

    check_eq("load_queue_empty", exp_load.size(), 0);
    check_eq("issue_queue_empty", exp_issue.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
